gcd_unit: RTL and testbench

- Self-contained N-bit greatest-common-divisor engine: controller FSM and datapath in one block, with valid/ready handshakes on both input and result.
- Parametrised successor to the fixed 4-bit subtractive GCD datapath. Adds generic width, an internal controller, zero-operand handling, result back-pressure and an optional binary (Stein) algorithm mode.
- Sits between an operand producer and a result consumer. Computes one operand pair at a time.

---
 rtl/gcd_unit.sv | 133 +++++++++++++
 tb/tb_gcd_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// N-bit GCD engine: IDLE/CALC/DONE controller plus datapath, valid/ready on both sides.
// Define GCD_STEIN_EN to replace the subtractive step with the binary (Stein) algorithm.
module gcd_unit #(
    parameter int N  = 8,
    parameter int KW = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] xin,
    input  logic [N-1:0] yin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] gcd,
    output logic         zflg,
    output logic         busy
);

    if (N < 2 || (2 ** KW) <= N) begin : g_bad_param
        $error("gcd_unit: need N >= 2 and 2**KW > N");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d, y_q, y_d;
    logic [N-1:0] gcd_q, gcd_d;
    logic         zflg_q, zflg_d;
    logic         x_zero, y_zero;
`ifdef GCD_STEIN_EN
    logic [KW-1:0] k_q, k_d;
`endif

    assign x_zero = (x_q == '0);
    assign y_zero = (y_q == '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gcd_d   = gcd_q;
        zflg_d  = zflg_q;
`ifdef GCD_STEIN_EN
        k_d     = k_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = xin;
                    y_d     = yin;
`ifdef GCD_STEIN_EN
                    k_d     = '0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef GCD_STEIN_EN
                // k counts the shared factors of two stripped off; restored on exit
                if (x_zero || y_zero) begin
                    gcd_d   = (x_q | y_q) << k_q;
                    zflg_d  = x_zero && y_zero;
                    state_d = DONE;
                end else if (x_q == y_q) begin
                    gcd_d   = x_q << k_q;
                    zflg_d  = 1'b0;
                    state_d = DONE;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q < y_q) begin
                    y_d = y_q - x_q;
                end else begin
                    x_d = x_q - y_q;
                end
`else
                if (x_zero || y_zero) begin
                    gcd_d   = x_q | y_q;
                    zflg_d  = x_zero && y_zero;
                    state_d = DONE;
                end else if (x_q == y_q) begin
                    gcd_d   = x_q;
                    zflg_d  = 1'b0;
                    state_d = DONE;
                end else if (x_q < y_q) begin
                    y_d = y_q - x_q;
                end else begin
                    x_d = x_q - y_q;
                end
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            gcd_q   <= '0;
            zflg_q  <= 1'b0;
`ifdef GCD_STEIN_EN
            k_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gcd_q   <= gcd_d;
            zflg_q  <= zflg_d;
`ifdef GCD_STEIN_EN
            k_q     <= k_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign gcd       = gcd_q;
    assign zflg      = zflg_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit (N=8): directed vector table, corner sequences, random sweep.
module tb_gcd_unit;
    localparam int N = 8;

    logic         clk, clr_n, in_valid, in_ready, out_valid, out_ready, zflg, busy;
    logic [N-1:0] xin, yin, gcd;

    int n_pass = 0;
    int n_total = 0;

    gcd_unit #(.N(N), .KW(4)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .xin(xin), .yin(yin), .out_valid(out_valid), .out_ready(out_ready),
        .gcd(gcd), .zflg(zflg), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] g;
        logic         z;
        int           lat_sub;
        int           lat_stein;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int pick_lat(input vec_t v);
`ifdef GCD_STEIN_EN
        return v.lat_stein;
`else
        return v.lat_sub;
`endif
    endfunction

    // Presents one pair, returns CALC cycles counted until out_valid rises.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit pulse,
                          output int lat, output bit busy_ok);
        int guard;
        guard = 0;
        lat = 0;
        busy_ok = 1'b1;
        while (!in_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        xin = a; yin = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        xin = N'($urandom); yin = N'($urandom);
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (!busy) busy_ok = 1'b0;
            if (pulse && lat == 40) begin in_valid = 1'b1; xin = 8'd6; yin = 8'd4; end
            if (pulse && lat == 42) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("out_valid_reached", int'(out_valid), 1);
    endtask

    vec_t vecs[7];

    initial begin
        int  lat;
        bit  bok;
        bit  seen;
        int  a, b;

        vecs[0] = '{8'd12,  8'd8,  8'd4,  1'b0, 3, 6};
        vecs[1] = '{8'd0,   8'd9,  8'd9,  1'b0, 1, 1};
        vecs[2] = '{8'd0,   8'd0,  8'd0,  1'b1, 1, 1};
        vecs[3] = '{8'd7,   8'd7,  8'd7,  1'b0, 1, 1};
        vecs[4] = '{8'd9,   8'd0,  8'd9,  1'b0, 1, 1};
        vecs[5] = '{8'd21,  8'd14, 8'd7,  1'b0, 3, 4};
        vecs[6] = '{8'd18,  8'd24, 8'd6,  1'b0, 4, 6};

        clk = 0; clr_n = 0; in_valid = 0; out_ready = 1; xin = '0; yin = '0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gcd", int'(gcd), 0);
        chk("rst_zflg", int'(zflg), 0);
        clr_n = 1;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, 1'b0, lat, bok);
            chk($sformatf("lat[%0d]", i), lat, pick_lat(vecs[i]));
            chk($sformatf("gcd[%0d]", i), int'(gcd), int'(vecs[i].g));
            chk($sformatf("zflg[%0d]", i), int'(zflg), int'(vecs[i].z));
            chk($sformatf("busy[%0d]", i), int'(busy && bok), 1);
            @(posedge clk); #1;
            chk($sformatf("idle_in_ready[%0d]", i), int'(in_ready), 1);
            chk($sformatf("idle_out_valid[%0d]", i), int'(out_valid), 0);
        end

        // long run with ignored in_valid pulses mid-CALC
        run_op(8'd255, 8'd1, 1'b1, lat, bok);
`ifdef GCD_STEIN_EN
        chk("lat_255_1", lat, 15);
`else
        chk("lat_255_1", lat, 255);
`endif
        chk("gcd_255_1", int'(gcd), 1);
        chk("busy_255_1", int'(bok), 1);
        @(posedge clk); #1;

        // back-pressure: result held while out_ready low
        out_ready = 0;
        run_op(8'd18, 8'd24, 1'b0, lat, bok);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid[%0d]", c), int'(out_valid), 1);
            chk($sformatf("bp_gcd[%0d]", c), int'(gcd), 6);
            chk($sformatf("bp_in_ready[%0d]", c), int'(in_ready), 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_gcd_kept", int'(gcd), 6);

        // reset in the middle of CALC
        xin = 8'd200; yin = 8'd3; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #2 clr_n = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_gcd", int'(gcd), 0);
        chk("midrst_zflg", int'(zflg), 0);
        chk("midrst_busy", int'(busy), 0);
        #3 clr_n = 1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midrst_no_output", int'(seen), 0);
        run_op(8'd21, 8'd14, 1'b0, lat, bok);
        chk("post_rst_gcd", int'(gcd), 7);

        // random sweep against a Euclid reference
        for (int r = 0; r < 1000; r++) begin
            a = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
            b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
            run_op(N'(a), N'(b), 1'b0, lat, bok);
            chk($sformatf("rand(%0d,%0d)", a, b), int'({zflg, gcd}),
                ((a == 0 && b == 0) ? 256 : 0) + ref_gcd(a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
